deadtime_gate_driver_3ph: RTL and testbench

//  Downstream stage of the 3-phase SPWM core: takes the per-phase comparator commands Va/Vb/Vc
//  and produces six gate signals (high/low switch per leg) with programmable dead time.

---
 rtl/tp3_pwm_pkg.sv | 15 +
 rtl/deadtime_leg.sv | 102 ++++++++++
 rtl/deadtime_gate_driver_3ph.sv | 87 ++++++++
 tb/tb_deadtime_gate_driver_3ph.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tp3_pwm_pkg.sv
// Shared types and defaults for the 3-phase PWM gate-driver slice.
// Holds the leg state encoding and the default dead-time counter width.
package tp3_pwm_pkg;

    localparam int TP3_CNT_W = 8;

    typedef enum logic [2:0] {
        S_OFF,
        S_DT_H,
        S_DT_L,
        S_HI,
        S_LO
    } leg_state_e;

endpackage

// File: rtl/deadtime_leg.sv
// One inverter leg: registered command, dead-time FSM, registered H/L gates.
// Latency: cmd edge -> old gate off 2 cycles later, new gate on after dead time; no backpressure.
module deadtime_leg
    import tp3_pwm_pkg::*;
#(
    parameter int CNT_W = TP3_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cmd,
    input  logic [CNT_W-1:0] dt_load,
    output logic             H,
    output logic             L
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    leg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_q, cmd_d;
    logic             h_q, h_d;
    logic             l_q, l_d;

    always_comb begin
        cmd_d   = cmd;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_OFF: begin
                if (run) begin
                    state_d = cmd_q ? S_DT_H : S_DT_L;
                    cnt_d   = dt_load;
                end
            end
            S_DT_H: begin
                // A command reversal restarts the full dead interval toward the new side.
                if (!cmd_q) begin
                    state_d = S_DT_L;
                    cnt_d   = dt_load;
                end else if (cnt_q == '0) begin
                    state_d = S_HI;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DT_L: begin
                if (cmd_q) begin
                    state_d = S_DT_H;
                    cnt_d   = dt_load;
                end else if (cnt_q == '0) begin
                    state_d = S_LO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_HI: begin
                if (!cmd_q) begin
                    state_d = S_DT_L;
                    cnt_d   = dt_load;
                end
            end
            S_LO: begin
                if (cmd_q) begin
                    state_d = S_DT_H;
                    cnt_d   = dt_load;
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
        endcase
        if (!run) begin
            state_d = S_OFF;
            cnt_d   = '0;
        end
        // Shutdown drops the gates straight away; turn-on always waits for a dead state first.
        h_d = run && (state_q == S_HI);
        l_d = run && (state_q == S_LO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            cmd_q   <= 1'b0;
            h_q     <= 1'b0;
            l_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            h_q     <= h_d;
            l_q     <= l_d;
        end
    end

    assign H = h_q;
    assign L = l_q;

endmodule

// File: rtl/deadtime_gate_driver_3ph.sv
// Six-gate driver for a 3-phase bridge with dead time, enable and latched fault shutdown.
// Latency: Vx -> gates 2 cycles (+dead time on turn-on); fault -> gates off 4 cycles; no backpressure.
module deadtime_gate_driver_3ph
    import tp3_pwm_pkg::*;
#(
    parameter int CNT_W  = TP3_CNT_W,
    parameter int DT_MIN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fault,
    input  logic             fault_clr,
    input  logic [CNT_W-1:0] dt_cfg,
    input  logic             Va,
    input  logic             Vb,
    input  logic             Vc,
    output logic             Ha,
    output logic             La,
    output logic             Hb,
    output logic             Lb,
    output logic             Hc,
    output logic             Lc,
    output logic             fault_lat,
    output logic             running
);

    if (DT_MIN < 1) begin : g_dt_min_chk
        $error("DT_MIN must be at least 1");
    end
    if (DT_MIN >= (1 << CNT_W)) begin : g_dt_fit_chk
        $error("DT_MIN does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] DT_FLOOR = CNT_W'(DT_MIN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             fault_meta_q, fault_meta_d;
    logic             fault_s_q, fault_s_d;
    logic             fault_lat_q, fault_lat_d;
    logic             running_q, running_d;
    logic [CNT_W-1:0] dt_eff;
    logic [CNT_W-1:0] dt_load;

    always_comb begin
        fault_meta_d = fault;
        fault_s_d    = fault_meta_q;
        // A live fault wins over a clear request in the same cycle.
        fault_lat_d  = fault_lat_q;
        if (fault_s_q) begin
            fault_lat_d = 1'b1;
        end else if (fault_clr) begin
            fault_lat_d = 1'b0;
        end
        running_d = en && !fault_lat_q;
        dt_eff    = (dt_cfg < DT_FLOOR) ? DT_FLOOR : dt_cfg;
        dt_load   = dt_eff - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_meta_q <= 1'b0;
            fault_s_q    <= 1'b0;
            fault_lat_q  <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            fault_meta_q <= fault_meta_d;
            fault_s_q    <= fault_s_d;
            fault_lat_q  <= fault_lat_d;
            running_q    <= running_d;
        end
    end

    assign fault_lat = fault_lat_q;
    assign running   = running_q;

    deadtime_leg #(.CNT_W(CNT_W)) u_leg_a (
        .clk(clk), .rst(rst), .run(running_q), .cmd(Va), .dt_load(dt_load), .H(Ha), .L(La)
    );
    deadtime_leg #(.CNT_W(CNT_W)) u_leg_b (
        .clk(clk), .rst(rst), .run(running_q), .cmd(Vb), .dt_load(dt_load), .H(Hb), .L(Lb)
    );
    deadtime_leg #(.CNT_W(CNT_W)) u_leg_c (
        .clk(clk), .rst(rst), .run(running_q), .cmd(Vc), .dt_load(dt_load), .H(Hc), .L(Lc)
    );

endmodule

// File: tb/tb_deadtime_gate_driver_3ph.sv
// Directed bench for the 3-phase dead-time gate driver; gates compared as {Ha,La,Hb,Lb,Hc,Lc}.
module tb_deadtime_gate_driver_3ph;

    logic       clk = 1'b0;
    logic       rst, en, fault, fault_clr, Va, Vb, Vc;
    logic [7:0] dt_cfg;
    logic       Ha, La, Hb, Lb, Hc, Lc, fault_lat, running;
    logic [5:0] g;
    int         errors = 0;
    int         checks = 0;
    int         overlap = 0;
    logic       ha_seen;

    always #5 clk = ~clk;

    assign g = {Ha, La, Hb, Lb, Hc, Lc};

    deadtime_gate_driver_3ph #(.CNT_W(8), .DT_MIN(2)) dut (
        .clk(clk), .rst(rst), .en(en), .fault(fault), .fault_clr(fault_clr),
        .dt_cfg(dt_cfg), .Va(Va), .Vb(Vb), .Vc(Vc),
        .Ha(Ha), .La(La), .Hb(Hb), .Lb(Lb), .Hc(Hc), .Lc(Lc),
        .fault_lat(fault_lat), .running(running)
    );

    always @(negedge clk) begin
        if ((Ha & La) | (Hb & Lb) | (Hc & Lc)) overlap++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; fault = 1'b0; fault_clr = 1'b0;
        dt_cfg = 8'd5; Va = 1'b1; Vb = 1'b0; Vc = 1'b1;
        tick(3);
        chk_eq("reset_outs", {24'd0, g, fault_lat, running}, 32'd0);

        // startup: running registers on edge 0, gates on after edge 7 with dt=5
        rst = 1'b0; en = 1'b1;
        tick(1);
        chk_eq("start_running", running, 1);
        chk_eq("start_gates_off", g, 6'b00_00_00);
        tick(6);
        chk_eq("start_dead_edge6", g, 6'b00_00_00);
        tick(1);
        chk_eq("start_gates_on", g, 6'b10_01_10);

        // Va 1->0 at edge n: Ha off after n+2, La on after n+7
        Va = 1'b0;
        tick(2);
        chk_eq("fall_ha_hold", g[5:4], 2'b10);
        tick(1);
        chk_eq("fall_ha_off", g[5:4], 2'b00);
        tick(4);
        chk_eq("fall_dead_n6", g[5:4], 2'b00);
        tick(1);
        chk_eq("fall_la_on", g[5:4], 2'b01);

        // dt_cfg=0 clamps to 2 in both directions
        dt_cfg = 8'd0; Va = 1'b1;
        tick(2);
        chk_eq("dtmin_rise_hold", g[5:4], 2'b01);
        tick(2);
        chk_eq("dtmin_rise_dead", g[5:4], 2'b00);
        tick(1);
        chk_eq("dtmin_rise_on", g[5:4], 2'b10);
        Va = 1'b0;
        tick(2);
        chk_eq("dtmin_fall_hold", g[5:4], 2'b10);
        tick(2);
        chk_eq("dtmin_fall_dead", g[5:4], 2'b00);
        tick(1);
        chk_eq("dtmin_fall_on", g[5:4], 2'b01);

        // 3-cycle pulse shorter than dt=6 is swallowed; La back after restarted dead time
        dt_cfg = 8'd6; Va = 1'b1;
        tick(3);
        chk_eq("pulse_la_off", g[5:4], 2'b00);
        Va = 1'b0;
        ha_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            ha_seen = ha_seen | Ha;
        end
        chk_eq("pulse_la_still_off", La, 0);
        tick(1);
        chk_eq("pulse_la_back", g[5:4], 2'b01);
        chk_eq("pulse_ha_never", ha_seen, 0);

        // one-cycle fault pulse
        fault = 1'b1;
        tick(1);
        fault = 1'b0;
        tick(1);
        chk_eq("fault_sync_lat0", fault_lat, 0);
        tick(1);
        chk_eq("fault_latched", {fault_lat, running}, 2'b11);
        tick(1);
        chk_eq("fault_run_drop", {running, g}, {1'b0, 6'b01_01_10});
        tick(1);
        chk_eq("fault_gates_off", g, 6'b00_00_00);

        // clear ignored while fault still present
        fault = 1'b1;
        tick(3);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        chk_eq("clr_ignored", fault_lat, 1);
        fault = 1'b0;
        tick(3);
        chk_eq("still_latched", {fault_lat, running}, 2'b10);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        chk_eq("clr_applied", {fault_lat, running}, 2'b00);
        tick(1);
        chk_eq("clr_running", running, 1);
        tick(7);
        chk_eq("restart_dead", g, 6'b00_00_00);
        tick(1);
        chk_eq("restart_on", g, 6'b01_01_10);

        // en dropped mid S_DT_H
        Va = 1'b1;
        tick(3);
        chk_eq("dth_la_off", g[5:4], 2'b00);
        en = 1'b0;
        tick(1);
        chk_eq("en_drop_running", {running, g}, {1'b0, 6'b00_01_10});
        tick(1);
        chk_eq("en_drop_gates", g, 6'b00_00_00);

        // re-enable with dt=3; dt change mid dead time has no effect
        dt_cfg = 8'd3; en = 1'b1;
        tick(1);
        chk_eq("reen_running", running, 1);
        tick(1);
        dt_cfg = 8'd20;
        tick(3);
        chk_eq("reen_dead", g, 6'b00_00_00);
        tick(1);
        chk_eq("reen_on_dt_kept", g, 6'b10_01_10);

        // en dropped mid S_HI
        en = 1'b0;
        tick(1);
        chk_eq("hi_drop_hold", g, 6'b10_01_10);
        tick(1);
        chk_eq("hi_drop_off", g, 6'b00_00_00);

        // rst asserted mid S_DT_L
        en = 1'b1; dt_cfg = 8'd3;
        tick(6);
        chk_eq("steady_dt3", g, 6'b10_01_10);
        Va = 1'b0; dt_cfg = 8'd8;
        tick(3);
        chk_eq("dtl_state", g, 6'b00_01_10);
        rst = 1'b1;
        tick(1);
        chk_eq("rst_mid_op", {24'd0, g, fault_lat, running}, 32'd0);
        rst = 1'b0;
        tick(1);
        chk_eq("rst_rel_running", {running, g}, {1'b1, 6'b00_00_00});
        tick(9);
        chk_eq("rst_rel_dead", g, 6'b00_00_00);
        tick(1);
        chk_eq("rst_rel_on", g, 6'b01_01_10);

        chk_eq("no_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
